user_edit_ctrl: RTL and testbench
=================================

Name: user_edit_ctrl

Overview:
Parametrised successor to the user-control block of the RTC front end. It accumulates per-field user edits (up/down with cursor movement) for the clock, alarm and timer register groups. On request it commits each edit to the RTC register bus by read-modify-write, with per-field modular wrap-around. It sits between the debounced button/switch logic and the RTC bus master, and is driven by the main sequencer.

Parameters:
NUM_FIELDS, 12, editable fields; the package field table must hold this many entries.
DATA_W, 8, RTC register data width.
ADDR_W, 8, RTC register address width.
DELTA_W, 8, signed pending-edit accumulator width per field.

Ports:
CLK  in  1  system clock
reset  in  1  synchronous, active-low reset
btn_up  in  1  one-cycle pulse, +1 to the field under the cursor
btn_down  in  1  one-cycle pulse, -1 to the field under the cursor
btn_left  in  1  one-cycle pulse, cursor -1
btn_right  in  1  one-cycle pulse, cursor +1
mode  in  2  00 off, 01 clock, 10 alarm, 11 timer
commit_req  in  1  level; high requests commit of the current group
bus_addr  out  ADDR_W  RTC register address
bus_rd_req  out  1  read request; held until bus_ack
bus_wr_req  out  1  write request; held until bus_ack
bus_wdata  out  DATA_W  write data
bus_rdata  in  DATA_W  read data; valid in the bus_ack cycle of a read
bus_ack  in  1  one-cycle transaction acknowledge
cursor  out  $clog2(NUM_FIELDS)  field index under edit
busy  out  1  commit in progress
commit_done  out  1  one-cycle pulse at the end of a complete commit
pending_any  out  1  OR over all nonzero deltas

Behaviour:
- Reset (reset=0 at a CLK edge): all deltas 0, cursor 0, FSM in IDLE, all outputs 0.
- Group ranges come from the package: clock 0-5 (sec, min, hour, day, month, year), alarm 6-8, timer 9-11.
- Mode change to a group when the cursor is outside it: cursor jumps to the group's first field on the next edge.
- Mode 00: buttons are ignored and deltas are retained.
- Cursor movement: left/right saturate at the group bounds. Left and right in the same cycle: no move.
- Edits: up → delta+1, down → delta-1, saturating at ±(2^(DELTA_W-1)-1). Up and down in the same cycle: no change.
- Buttons are ignored while busy=1.
- FSM states: IDLE, SCAN, RD, CALC, WR, NEXT, DONE.
  - IDLE→SCAN when commit_req=1 and mode≠00; busy asserts on that edge.
  - SCAN walks the group's fields from first to last, one field per cycle. A field with delta=0 is skipped. A field with delta≠0 goes to RD.
  - RD: bus_addr=field addr and bus_rd_req=1 until bus_ack. On ack, latch rdata and go to CALC.
  - CALC: v=rdata; if v is outside [min,max], v=min. Then v+=delta and, one step per cycle, add or subtract span=max-min+1 until v is in [min,max]. Bounded by ceil(|delta|/span)+1 cycles.
  - WR: bus_wdata=v and bus_wr_req=1 until bus_ack. On ack, clear that field's delta and go to NEXT.
  - NEXT: go to SCAN at the following field. After the last field, go to DONE.
  - DONE: commit_done=1 for one cycle, then IDLE with busy=0.
- Abort: if commit_req falls mid-commit, an outstanding transaction completes (a read also completes its write), then the FSM goes to IDLE with no commit_done. Unprocessed deltas are kept.
- Group with no nonzero delta: SCAN→DONE with no bus traffic; commit_done still pulses.
- bus_rd_req and bus_wr_req are never high together, and never re-assert in the ack cycle.
- A reset low mid-transaction drops all requests on that edge. The bus master must tolerate this.

Optional Feature:
USER_EDIT_BCD_EN.
- Defined: bus_rdata is BCD and is converted to binary before CALC; bus_wdata is binary converted to BCD. A BCD nibble >9 is treated as out-of-range, so v=min.
- Undefined: bus data is plain binary. min/max are binary in both cases.

Decomposition:
- Package user_edit_pkg holds:
  - field table: addr, min, max, group per index;
  - mode encoding;
  - FSM state enum;
  - group first/last index constants.
- Sub-module field_wrap_alu: the iterative CALC arithmetic with start/done handshake, plus the optional BCD conversion.

Test Plan:
- Mode 01, cursor→1 (min, addr 0x22, 0..59), btn_up ×3, commit_req; bus returns 0x58 (binary) → write 0x01 to 0x22, delta cleared, commit_done pulses once.
- Mode 01, cursor→2 (hour, 0..23), btn_down ×30, rdata 5 → write 23; CALC takes ≤3 cycles.
- 130 btn_up on one field → delta saturates at 127; btn_up and btn_down in the same cycle → delta unchanged.
- Mode 10 with cursor at 0 → cursor=6; btn_right ×5 → cursor=8 (saturated).
- commit_req drops during the RD of the first of two edited fields → read, then write, then IDLE; second delta retained; no commit_done.
- USER_EDIT_BCD_EN: rdata 0x59, delta +1 on the sec field → wdata 0x00; rdata 0x5A → treated as min, wdata 0x01.

Source files
------------

// File: rtl/user_edit_ctrl_pkg.sv
// Shared definitions for the user edit controller: field table, mode encoding,
// commit FSM states and group index ranges.
package user_edit_pkg;

    localparam int unsigned NUM_FIELDS_TAB = 12;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_CLOCK = 2'b01,
        MODE_ALARM = 2'b10,
        MODE_TIMER = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_RD,
        ST_CALC,
        ST_WR,
        ST_NEXT,
        ST_DONE
    } state_e;

    localparam int unsigned CLOCK_FIRST = 0;
    localparam int unsigned CLOCK_LAST  = 5;
    localparam int unsigned ALARM_FIRST = 6;
    localparam int unsigned ALARM_LAST  = 8;
    localparam int unsigned TIMER_FIRST = 9;
    localparam int unsigned TIMER_LAST  = 11;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] lo;
        logic [7:0] hi;
        mode_e      grp;
    } field_t;

    // Limits are binary; the bus encoding is handled in the arithmetic unit.
    localparam field_t FIELD_TAB [NUM_FIELDS_TAB] = '{
        '{8'h21, 8'd0, 8'd59, MODE_CLOCK},   // sec
        '{8'h22, 8'd0, 8'd59, MODE_CLOCK},   // min
        '{8'h23, 8'd0, 8'd23, MODE_CLOCK},   // hour
        '{8'h24, 8'd1, 8'd31, MODE_CLOCK},   // day
        '{8'h25, 8'd1, 8'd12, MODE_CLOCK},   // month
        '{8'h26, 8'd0, 8'd99, MODE_CLOCK},   // year
        '{8'h30, 8'd0, 8'd59, MODE_ALARM},   // alarm sec
        '{8'h31, 8'd0, 8'd59, MODE_ALARM},   // alarm min
        '{8'h32, 8'd0, 8'd23, MODE_ALARM},   // alarm hour
        '{8'h40, 8'd0, 8'd59, MODE_TIMER},   // timer sec
        '{8'h41, 8'd0, 8'd59, MODE_TIMER},   // timer min
        '{8'h42, 8'd0, 8'd99, MODE_TIMER}    // timer hour
    };

    function automatic int unsigned grp_first(input mode_e m);
        case (m)
            MODE_CLOCK: return CLOCK_FIRST;
            MODE_ALARM: return ALARM_FIRST;
            MODE_TIMER: return TIMER_FIRST;
            default:    return 0;
        endcase
    endfunction

    function automatic int unsigned grp_last(input mode_e m);
        case (m)
            MODE_CLOCK: return CLOCK_LAST;
            MODE_ALARM: return ALARM_LAST;
            MODE_TIMER: return TIMER_LAST;
            default:    return 0;
        endcase
    endfunction

endpackage

// File: rtl/user_edit_ctrl_field_wrap_alu.sv
// Iterative modular field arithmetic: clamp the read value, add the delta, fold
// back into [lo,hi] one span per cycle. USER_EDIT_BCD_EN selects BCD bus data.
module field_wrap_alu #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DELTA_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_W-1:0]         rdata,
    input  logic signed [DELTA_W-1:0] delta,
    input  logic [DATA_W-1:0]         lo,
    input  logic [DATA_W-1:0]         hi,
    output logic                      done,
    output logic [DATA_W-1:0]         result
);

    localparam int unsigned VW = ((DATA_W > DELTA_W) ? DATA_W : DELTA_W) + 2;
    localparam logic signed [VW-1:0] V_ONE = {{(VW-1){1'b0}}, 1'b1};

`ifdef USER_EDIT_BCD_EN
    function automatic logic [DATA_W:0] bcd2bin(input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] acc;
        logic [3:0]        nib;
        logic              bad;
        acc = '0;
        bad = 1'b0;
        for (int unsigned i = DATA_W / 4; i > 0; i--) begin
            nib = b[4*(i-1) +: 4];
            if (nib > 4'd9) bad = 1'b1;
            acc = acc * DATA_W'(10) + DATA_W'(nib);
        end
        return {bad, acc};
    endfunction

    function automatic logic [DATA_W-1:0] bin2bcd(input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] tmp;
        logic [DATA_W-1:0] dig;
        logic [DATA_W-1:0] res;
        tmp = b;
        res = '0;
        for (int unsigned i = 0; i < DATA_W / 4; i++) begin
            dig            = tmp % DATA_W'(10);
            res[4*i +: 4]  = dig[3:0];
            tmp            = tmp / DATA_W'(10);
        end
        return res;
    endfunction
`endif

    logic signed [VW-1:0] v_q, v_d;
    logic                 act_q, act_d;
    logic [DATA_W-1:0]    base_bin;
    logic [DATA_W-1:0]    base_v;
    logic                 base_bad;
    logic signed [VW-1:0] lo_s, hi_s, span_s, base_s, delta_s;
    logic                 in_range;

    always_comb begin
`ifdef USER_EDIT_BCD_EN
        {base_bad, base_bin} = bcd2bin(rdata);
`else
        base_bad = 1'b0;
        base_bin = rdata;
`endif
        base_v   = (base_bad || base_bin < lo || base_bin > hi) ? lo : base_bin;
        lo_s     = VW'(lo);
        hi_s     = VW'(hi);
        span_s   = hi_s - lo_s + V_ONE;
        base_s   = VW'(base_v);
        delta_s  = VW'(delta);
        in_range = (v_q >= lo_s) && (v_q <= hi_s);
        done     = act_q && in_range;
`ifdef USER_EDIT_BCD_EN
        result   = bin2bcd(v_q[DATA_W-1:0]);
`else
        result   = v_q[DATA_W-1:0];
`endif

        v_d   = v_q;
        act_d = act_q;
        if (start) begin
            v_d   = base_s + delta_s;
            act_d = 1'b1;
        end else if (act_q) begin
            if (v_q > hi_s)      v_d = v_q - span_s;
            else if (v_q < lo_s) v_d = v_q + span_s;
            else                 act_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v_q   <= '0;
            act_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            act_q <= act_d;
        end
    end

endmodule

// File: rtl/user_edit_ctrl.sv
// User edit controller: per-field delta accumulation with cursor, and a commit
// FSM that read-modify-writes each edited field over the RTC bus (USER_EDIT_BCD_EN).
module user_edit_ctrl
    import user_edit_pkg::*;
#(
    parameter int unsigned NUM_FIELDS = 12,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DELTA_W    = 8
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          btn_up,
    input  logic                          btn_down,
    input  logic                          btn_left,
    input  logic                          btn_right,
    input  logic [1:0]                    mode,
    input  logic                          commit_req,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic                          bus_rd_req,
    output logic                          bus_wr_req,
    output logic [DATA_W-1:0]             bus_wdata,
    input  logic [DATA_W-1:0]             bus_rdata,
    input  logic                          bus_ack,
    output logic [$clog2(NUM_FIELDS)-1:0] cursor,
    output logic                          busy,
    output logic                          commit_done,
    output logic                          pending_any
);

    localparam int unsigned CUR_W = $clog2(NUM_FIELDS);
    localparam logic [CUR_W-1:0]          CUR_ONE = {{(CUR_W-1){1'b0}}, 1'b1};
    localparam logic signed [DELTA_W-1:0] D_ONE   = {{(DELTA_W-1){1'b0}}, 1'b1};
    localparam logic signed [DELTA_W-1:0] D_MAX   = {1'b0, {(DELTA_W-1){1'b1}}};
    localparam logic signed [DELTA_W-1:0] D_MIN   = -D_MAX;

    mode_e                      mode_m;
    state_e                     state_q, state_d;
    logic [CUR_W-1:0]           cursor_q, cursor_d;
    logic [CUR_W-1:0]           idx_q, idx_d;
    logic [CUR_W-1:0]           last_q, last_d;
    logic signed [DELTA_W-1:0]  delta_q [NUM_FIELDS];
    logic signed [DELTA_W-1:0]  delta_d [NUM_FIELDS];
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic                       rd_q, rd_d, wr_q, wr_d;
    logic [DATA_W-1:0]          wdata_q, wdata_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [CUR_W-1:0]           g_first, g_last;
    logic                       alu_start, alu_done;
    logic [DATA_W-1:0]          alu_result;

    assign mode_m  = mode_e'(mode);
    assign g_first = CUR_W'(grp_first(mode_m));
    assign g_last  = CUR_W'(grp_last(mode_m));

    assign alu_start = (state_q == ST_RD) && bus_ack;

    field_wrap_alu #(
        .DATA_W  (DATA_W),
        .DELTA_W (DELTA_W)
    ) u_alu (
        .clk    (CLK),
        .reset  (reset),
        .start  (alu_start),
        .rdata  (bus_rdata),
        .delta  (delta_q[idx_q]),
        .lo     (DATA_W'(FIELD_TAB[idx_q].lo)),
        .hi     (DATA_W'(FIELD_TAB[idx_q].hi)),
        .done   (alu_done),
        .result (alu_result)
    );

    always_comb begin
        cursor_d = cursor_q;
        delta_d  = delta_q;
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        // A cursor outside the selected group jumps first; buttons wait a cycle.
        if (mode_m != MODE_OFF) begin
            if (cursor_q < g_first || cursor_q > g_last) begin
                cursor_d = g_first;
            end else if (!busy_q) begin
                if (btn_left && !btn_right && cursor_q != g_first)
                    cursor_d = cursor_q - CUR_ONE;
                else if (btn_right && !btn_left && cursor_q != g_last)
                    cursor_d = cursor_q + CUR_ONE;
                if (btn_up && !btn_down && delta_q[cursor_q] != D_MAX)
                    delta_d[cursor_q] = delta_q[cursor_q] + D_ONE;
                else if (btn_down && !btn_up && delta_q[cursor_q] != D_MIN)
                    delta_d[cursor_q] = delta_q[cursor_q] - D_ONE;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (commit_req && mode_m != MODE_OFF) begin
                    state_d = ST_SCAN;
                    busy_d  = 1'b1;
                    idx_d   = g_first;
                    last_d  = g_last;
                end
            end
            ST_SCAN: begin
                if (!commit_req) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (delta_q[idx_q] != '0) begin
                    state_d = ST_RD;
                    addr_d  = ADDR_W'(FIELD_TAB[idx_q].addr);
                    rd_d    = 1'b1;
                end else if (idx_q == last_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + CUR_ONE;
                end
            end
            ST_RD: begin
                if (bus_ack) begin
                    rd_d    = 1'b0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (alu_done) begin
                    wdata_d = alu_result;
                    wr_d    = 1'b1;
                    state_d = ST_WR;
                end
            end
            // Once a read is issued the write always follows, even on abort.
            ST_WR: begin
                if (bus_ack) begin
                    wr_d           = 1'b0;
                    delta_d[idx_q] = '0;
                    if (!commit_req) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (!commit_req) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (idx_q == last_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + CUR_ONE;
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cursor_q <= '0;
            idx_q    <= '0;
            last_q   <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_FIELDS; i++) delta_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            delta_q  <= delta_d;
        end
    end

    always_comb begin
        pending_any = 1'b0;
        for (int unsigned i = 0; i < NUM_FIELDS; i++)
            if (delta_q[i] != '0) pending_any = 1'b1;
    end

    assign bus_addr    = addr_q;
    assign bus_rd_req  = rd_q;
    assign bus_wr_req  = wr_q;
    assign bus_wdata   = wdata_q;
    assign cursor      = cursor_q;
    assign busy        = busy_q;
    assign commit_done = done_q;

endmodule

// File: tb/tb_user_edit_ctrl.sv
// Directed self-checking bench for user_edit_ctrl; expectations follow USER_EDIT_BCD_EN.
module tb_user_edit_ctrl;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       commit_req = 1'b0;
    logic [7:0] bus_addr, bus_wdata;
    logic [7:0] bus_rdata = 8'h00;
    logic       bus_rd_req, bus_wr_req;
    logic       bus_ack = 1'b0;
    logic [3:0] cursor;
    logic       busy, commit_done, pending_any;

    int n_cmp = 0, n_fail = 0;
    int done_cnt = 0, both_cnt = 0;

`ifdef USER_EDIT_BCD_EN
    localparam logic [7:0] RD_58 = 8'h58, RD_5 = 8'h05, RD_10 = 8'h10, RD_23 = 8'h23;
    localparam logic [7:0] W_HOUR23 = 8'h23, W_SEC53 = 8'h53, W_HOUR7 = 8'h07;
    localparam logic [7:0] W_OOR1 = 8'h00, W_11 = 8'h11;
`else
    localparam logic [7:0] RD_58 = 8'd58, RD_5 = 8'd5, RD_10 = 8'd10, RD_23 = 8'd23;
    localparam logic [7:0] W_HOUR23 = 8'd23, W_SEC53 = 8'd53, W_HOUR7 = 8'd7;
    localparam logic [7:0] W_OOR1 = 8'd1, W_11 = 8'd11;
`endif

    user_edit_ctrl #(
        .NUM_FIELDS (12),
        .DATA_W     (8),
        .ADDR_W     (8),
        .DELTA_W    (8)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .mode        (mode),
        .commit_req  (commit_req),
        .bus_addr    (bus_addr),
        .bus_rd_req  (bus_rd_req),
        .bus_wr_req  (bus_wr_req),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack),
        .cursor      (cursor),
        .busy        (busy),
        .commit_done (commit_done),
        .pending_any (pending_any)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (commit_done) done_cnt <= done_cnt + 1;
        if (bus_rd_req && bus_wr_req) both_cnt <= both_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // which: 0 up, 1 down, 2 left, 3 right, 4 up+down, 5 left+right
    task automatic pulse(input int which, input int n);
        btn_up    = (which == 0 || which == 4);
        btn_down  = (which == 1 || which == 4);
        btn_left  = (which == 2 || which == 5);
        btn_right = (which == 3 || which == 5);
        repeat (n) tick();
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    endtask

    task automatic wait_req(input bit wr, input int budget, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            if (wr ? bus_wr_req : bus_rd_req) begin
                got = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic ack(input logic [7:0] d);
        bus_rdata = d;
        bus_ack   = 1'b1;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = 8'h00;
    endtask

    task automatic do_rmw(input logic [7:0] rd, output bit got_rd, output logic [7:0] rd_addr,
                          output bit got_wr, output logic [7:0] wr_addr,
                          output logic [7:0] wdata, output int calc_cyc);
        int c;
        wait_req(1'b0, 30, got_rd, c);
        rd_addr = bus_addr;
        if (got_rd) ack(rd);
        wait_req(1'b1, 40, got_wr, calc_cyc);
        wr_addr = bus_addr;
        wdata   = bus_wdata;
        if (got_wr) ack(8'h00);
    endtask

    task automatic finish_commit(output bit got);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (commit_done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        commit_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        n_cmp++; if (cursor !== 4'd0) begin n_fail++; $display("FAIL reset_cursor: got %0d want 0", cursor); end
        n_cmp++; if ({busy, commit_done, pending_any, bus_rd_req, bus_wr_req} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00000", {busy, commit_done, pending_any, bus_rd_req, bus_wr_req}); end
        n_cmp++; if ({bus_addr, bus_wdata} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_bus: got %h want 0000", {bus_addr, bus_wdata}); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mode_off();
        mode = 2'b00;
        pulse(0, 1);
        pulse(3, 1);
        n_cmp++; if (pending_any !== 1'b0) begin n_fail++; $display("FAIL off_edit: pending got %b want 0", pending_any); end
        n_cmp++; if (cursor !== 4'd0) begin n_fail++; $display("FAIL off_cursor: got %0d want 0", cursor); end
        commit_req = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL off_commit: busy got %b want 0", busy); end
        commit_req = 1'b0;
        tick();
    endtask

    task automatic test_clock_min();
        bit gr, gw, gd; logic [7:0] ra, wa, wd; int cc, d0;
        mode = 2'b01;
        tick();
        pulse(3, 1);
        n_cmp++; if (cursor !== 4'd1) begin n_fail++; $display("FAIL min_cursor: got %0d want 1", cursor); end
        pulse(0, 3);
        n_cmp++; if (pending_any !== 1'b1) begin n_fail++; $display("FAIL min_pending: got %b want 1", pending_any); end
        d0 = done_cnt;
        commit_req = 1'b1;
        do_rmw(RD_58, gr, ra, gw, wa, wd, cc);
        n_cmp++; if (!gr || ra !== 8'h22) begin n_fail++; $display("FAIL min_rd: got req=%b addr=%h want 1/22", gr, ra); end
        n_cmp++; if (!gw || wa !== 8'h22 || wd !== 8'h01) begin
            n_fail++; $display("FAIL min_wr: got req=%b addr=%h data=%h want 1/22/01", gw, wa, wd); end
        finish_commit(gd);
        n_cmp++; if (!gd || done_cnt !== d0 + 1) begin
            n_fail++; $display("FAIL min_done: seen=%b pulses=%0d want 1/1", gd, done_cnt - d0); end
        n_cmp++; if (pending_any !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL min_clear: pending=%b busy=%b want 0/0", pending_any, busy); end
    endtask

    task automatic test_hour_wrap();
        bit gr, gw, gd; logic [7:0] ra, wa, wd; int cc;
        pulse(3, 1);
        pulse(1, 30);
        commit_req = 1'b1;
        do_rmw(RD_5, gr, ra, gw, wa, wd, cc);
        n_cmp++; if (!gr || ra !== 8'h23) begin n_fail++; $display("FAIL hour_rd: got req=%b addr=%h want 1/23", gr, ra); end
        n_cmp++; if (!gw || wd !== W_HOUR23) begin n_fail++; $display("FAIL hour_wr: got req=%b data=%h want 1/%h", gw, wd, W_HOUR23); end
        n_cmp++; if (cc > 3) begin n_fail++; $display("FAIL hour_calc_cycles: got %0d want <=3", cc); end
        finish_commit(gd);
        n_cmp++; if (!gd) begin n_fail++; $display("FAIL hour_done: seen %b want 1", gd); end
    endtask

    task automatic test_saturation();
        bit gr, gw, gd; logic [7:0] ra, wa, wd; int cc;
        pulse(2, 2);
        n_cmp++; if (cursor !== 4'd0) begin n_fail++; $display("FAIL sat_cursor_left: got %0d want 0", cursor); end
        pulse(1, 130);
        pulse(3, 2);
        pulse(0, 130);
        pulse(4, 2);
        mode = 2'b00;
        pulse(0, 3);
        mode = 2'b01;
        tick();
        n_cmp++; if (cursor !== 4'd2) begin n_fail++; $display("FAIL sat_cursor_keep: got %0d want 2", cursor); end
        commit_req = 1'b1;
        do_rmw(8'h00, gr, ra, gw, wa, wd, cc);
        n_cmp++; if (!gw || ra !== 8'h21 || wd !== W_SEC53) begin
            n_fail++; $display("FAIL sat_neg: got addr=%h data=%h want 21/%h", ra, wd, W_SEC53); end
        do_rmw(8'h00, gr, ra, gw, wa, wd, cc);
        n_cmp++; if (!gw || ra !== 8'h23 || wd !== W_HOUR7) begin
            n_fail++; $display("FAIL sat_pos: got addr=%h data=%h want 23/%h", ra, wd, W_HOUR7); end
        finish_commit(gd);
        n_cmp++; if (!gd || pending_any !== 1'b0) begin
            n_fail++; $display("FAIL sat_done: seen=%b pending=%b want 1/0", gd, pending_any); end
    endtask

    task automatic test_cursor_modes();
        pulse(2, 2);
        mode = 2'b10;
        tick();
        n_cmp++; if (cursor !== 4'd6) begin n_fail++; $display("FAIL alarm_jump: got %0d want 6", cursor); end
        pulse(3, 5);
        n_cmp++; if (cursor !== 4'd8) begin n_fail++; $display("FAIL alarm_right_sat: got %0d want 8", cursor); end
        pulse(2, 1);
        pulse(5, 2);
        n_cmp++; if (cursor !== 4'd7) begin n_fail++; $display("FAIL left_right_same: got %0d want 7", cursor); end
        mode = 2'b11;
        tick();
        n_cmp++; if (cursor !== 4'd9) begin n_fail++; $display("FAIL timer_jump: got %0d want 9", cursor); end
        pulse(2, 3);
        n_cmp++; if (cursor !== 4'd9) begin n_fail++; $display("FAIL timer_left_sat: got %0d want 9", cursor); end
    endtask

    task automatic test_out_of_range();
        bit gr, gw, gd; logic [7:0] ra, wa, wd; int cc;
        mode = 2'b01;
        tick();
        n_cmp++; if (cursor !== 4'd0) begin n_fail++; $display("FAIL clock_jump: got %0d want 0", cursor); end
        pulse(0, 1);
        commit_req = 1'b1;
        do_rmw(8'h59, gr, ra, gw, wa, wd, cc);
        n_cmp++; if (!gw || wd !== W_OOR1) begin n_fail++; $display("FAIL sec_59: got data=%h want %h", wd, W_OOR1); end
        finish_commit(gd);
        pulse(0, 1);
        commit_req = 1'b1;
        do_rmw(8'h5A, gr, ra, gw, wa, wd, cc);
        n_cmp++; if (!gw || wd !== 8'h01) begin n_fail++; $display("FAIL sec_5a: got data=%h want 01", wd); end
        finish_commit(gd);
    endtask

    task automatic test_abort();
        bit gr, gw, gd, saw_rd; logic [7:0] ra, wa, wd; int cc, d0;
        pulse(3, 1); pulse(0, 1);
        pulse(3, 1); pulse(0, 1);
        d0 = done_cnt;
        commit_req = 1'b1;
        wait_req(1'b0, 30, gr, cc);
        n_cmp++; if (!gr || bus_addr !== 8'h22) begin n_fail++; $display("FAIL abort_rd: got req=%b addr=%h want 1/22", gr, bus_addr); end
        commit_req = 1'b0;
        tick(); tick();
        n_cmp++; if (bus_rd_req !== 1'b1) begin n_fail++; $display("FAIL abort_rd_held: got %b want 1", bus_rd_req); end
        ack(RD_10);
        n_cmp++; if (bus_rd_req !== 1'b0) begin n_fail++; $display("FAIL abort_rd_drop: got %b want 0", bus_rd_req); end
        wait_req(1'b1, 40, gw, cc);
        n_cmp++; if (!gw || bus_wdata !== W_11) begin n_fail++; $display("FAIL abort_wr: got req=%b data=%h want 1/%h", gw, bus_wdata, W_11); end
        if (gw) ack(8'h00);
        saw_rd = 1'b0;
        repeat (6) begin
            if (bus_rd_req || bus_wr_req) saw_rd = 1'b1;
            tick();
        end
        n_cmp++; if (saw_rd || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: traffic=%b busy=%b want 0/0", saw_rd, busy); end
        n_cmp++; if (done_cnt !== d0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); end
        n_cmp++; if (pending_any !== 1'b1) begin n_fail++; $display("FAIL abort_retained: pending got %b want 1", pending_any); end
        commit_req = 1'b1;
        do_rmw(RD_23, gr, ra, gw, wa, wd, cc);
        n_cmp++; if (!gw || ra !== 8'h23 || wd !== 8'h00) begin
            n_fail++; $display("FAIL retained_hour: got addr=%h data=%h want 23/00", ra, wd); end
        finish_commit(gd);
    endtask

    task automatic test_empty_group();
        bit gd; int traffic, d0;
        mode = 2'b10;
        tick();
        d0 = done_cnt;
        traffic = 0;
        gd = 1'b0;
        commit_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus_rd_req || bus_wr_req) traffic++;
            if (commit_done) begin gd = 1'b1; break; end
            tick();
        end
        commit_req = 1'b0;
        tick(); tick();
        n_cmp++; if (!gd || traffic != 0) begin n_fail++; $display("FAIL empty_group: done=%b traffic=%0d want 1/0", gd, traffic); end
        n_cmp++; if (done_cnt !== d0 + 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL empty_single: pulses=%0d busy=%b want 1/0", done_cnt - d0, busy); end
    endtask

    task automatic test_reset_midtxn();
        bit gr; int cc;
        mode = 2'b01;
        tick();
        pulse(0, 1);
        commit_req = 1'b1;
        wait_req(1'b0, 30, gr, cc);
        reset = 1'b0;
        tick();
        n_cmp++; if (!gr || bus_rd_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: seen=%b rd=%b busy=%b want 1/0/0", gr, bus_rd_req, busy); end
        n_cmp++; if (pending_any !== 1'b0 || cursor !== 4'd0) begin
            n_fail++; $display("FAIL reset_mid_state: pending=%b cursor=%0d want 0/0", pending_any, cursor); end
        commit_req = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_protocol();
        n_cmp++; if (both_cnt != 0) begin n_fail++; $display("FAIL rd_wr_overlap: got %0d cycles want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_mode_off();
        test_clock_min();
        test_hour_wrap();
        test_saturation();
        test_cursor_modes();
        test_out_of_range();
        test_abort();
        test_empty_group();
        test_reset_midtxn();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
